// File: rtl/idwt53_stream.sv
// rtl/idwt53_stream.sv - streaming inverse LeGall 5/3 lifting, one coefficient pair in, one sample pair out.
// Internal even/odd values are 18-bit and unsaturated; clamping happens only when loading the output register.
module idwt53_stream (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [15:0] s_low,
   input  logic [15:0] s_high,
   input  logic        s_last,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [15:0] m_even,
   output logic [15:0] m_odd,
   output logic        m_last
);

   typedef enum logic [1:0] {FIRST, RUN, FLUSH} state_t;

   state_t state, state_next;
   logic   live;
   logic   out_free, accept, load_run, load_flush;

   logic signed [17:0] x_prev, d_prev;
   logic signed [17:0] s_ext, d_ext, d_left;
   logic signed [17:0] lift_sum, x_new, pred_sum, odd_run, odd_flush;

   function automatic logic [15:0] sat16(input logic signed [17:0] v);
      if (v > 18'sd32767)
         return 16'h7fff;
      else if (v < -18'sd32768)
         return 16'h8000;
      else
         return v[15:0];
   endfunction

   // Operand ranges of 16-bit inputs keep every sum below within 18 signed bits.
   always_comb begin
      s_ext     = {{2{s_low[15]}}, s_low};
      d_ext     = {{2{s_high[15]}}, s_high};
      d_left    = (state == FIRST) ? d_ext : d_prev;
      lift_sum  = d_left + d_ext + 18'sd2;
      x_new     = s_ext - (lift_sum >>> 2);
      pred_sum  = x_prev + x_new;
      odd_run   = d_prev + (pred_sum >>> 1);
      odd_flush = d_prev + x_prev;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= FIRST;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      s_ready    = 1'b0;
      load_run   = 1'b0;
      load_flush = 1'b0;
      out_free   = !m_valid || m_ready;
      case (state)
         FIRST: begin
            s_ready = live;
            if (s_valid && live)
               state_next = s_last ? FLUSH : RUN;
         end
         RUN: begin
            s_ready = out_free;
            if (s_valid && out_free) begin
               load_run = 1'b1;
               if (s_last)
                  state_next = FLUSH;
            end
         end
         FLUSH: begin
            if (out_free) begin
               load_flush = 1'b1;
               state_next = FIRST;
            end
         end
         default: state_next = FIRST;
      endcase
   end

   assign accept = s_valid && s_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         live    <= 1'b0;
         x_prev  <= '0;
         d_prev  <= '0;
         m_valid <= 1'b0;
         m_even  <= '0;
         m_odd   <= '0;
         m_last  <= 1'b0;
      end else begin
         live <= 1'b1;
         if (accept) begin
            x_prev <= x_new;
            d_prev <= d_ext;
         end
         if (load_run) begin
            m_valid <= 1'b1;
            m_even  <= sat16(x_prev);
            m_odd   <= sat16(odd_run);
            m_last  <= 1'b0;
         end else if (load_flush) begin
            // Right-edge mirror x[2N] = x[2N-2] collapses the predict step to d + x.
            m_valid <= 1'b1;
            m_even  <= sat16(x_prev);
            m_odd   <= sat16(odd_flush);
            m_last  <= 1'b1;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_idwt53_stream.sv
// tb/tb_idwt53_stream.sv - randomized and directed bench for idwt53_stream against a whole-line arithmetic model.
module tb_idwt53_stream;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] s_low = '0;
   logic [15:0] s_high = '0;
   logic        s_last = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [15:0] m_even;
   logic [15:0] m_odd;
   logic        m_last;

   always #5 clk = ~clk;

   idwt53_stream dut (
      .clk     (clk),
      .reset   (reset),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_low   (s_low),
      .s_high  (s_high),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_even  (m_even),
      .m_odd   (m_odd),
      .m_last  (m_last)
   );

   typedef struct {
      int e;
      int o;
      bit l;
   } pair_t;

   pair_t exp_q[$];
   int    cur_s[$];
   int    cur_d[$];
   int    acc_cyc[$];
   int    tests = 0;
   int    errors = 0;
   int    rdy_prob = 100;
   bit    stall_arm = 1'b0;
   int    stall_cnt = 0;
   bit    bp_check = 1'b0;
   int    cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int fdiv(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0)))
         q = q - 1;
      return q;
   endfunction

   function automatic int sat(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int rnd16();
      logic signed [15:0] v;
      v = 16'($urandom);
      case ($urandom_range(5))
         0: v = 16'sh7fff;
         1: v = 16'sh8000;
         default: ;
      endcase
      return int'(v);
   endfunction

   task automatic push_exp(input int e, input int o, input bit l);
      pair_t p;
      p.e = e;
      p.o = o;
      p.l = l;
      exp_q.push_back(p);
   endtask

   task automatic model_line();
      int n;
      int dm1;
      int x[];
      n = cur_s.size();
      x = new[2 * n + 1];
      for (int k = 0; k < n; k++) begin
         dm1 = (k == 0) ? cur_d[0] : cur_d[k - 1];
         x[2 * k] = cur_s[k] - fdiv(dm1 + cur_d[k] + 2, 4);
      end
      x[2 * n] = x[2 * n - 2];
      for (int k = 0; k < n; k++) begin
         x[2 * k + 1] = cur_d[k] + fdiv(x[2 * k] + x[2 * k + 2], 2);
         push_exp(sat(x[2 * k]), sat(x[2 * k + 1]), k == n - 1);
      end
   endtask

   task automatic send_pair(input int s, input int d, input bit last, input int gap);
      int w;
      @(negedge clk);
      while ($urandom_range(99) < gap) begin
         s_valid = 1'b0;
         s_low   = 16'($urandom);
         s_high  = 16'($urandom);
         s_last  = 1'($urandom);
         @(negedge clk);
      end
      s_valid = 1'b1;
      s_low   = 16'(s);
      s_high  = 16'(d);
      s_last  = last;
      w = 0;
      #2;
      while (!s_ready) begin
         @(negedge clk);
         #2;
         w++;
         if (w > 500) begin
            check("s_ready_timeout", 0, 1);
            s_valid = 1'b0;
            return;
         end
      end
      acc_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic send_line(input int gap);
      for (int i = 0; i < cur_s.size(); i++)
         send_pair(cur_s[i], cur_d[i], i == cur_s.size() - 1, gap);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() > 0 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0)
         check("drain_timeout", exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin : monitor
      pair_t p;
      bit    hold_v;
      int    held_e, held_o, held_l;
      hold_v = 1'b0;
      forever begin
         @(negedge clk);
         if (stall_arm && m_valid) begin
            stall_cnt = 3;
            stall_arm = 1'b0;
         end
         if (stall_cnt > 0) begin
            m_ready = 1'b0;
            stall_cnt--;
         end else begin
            m_ready = ($urandom_range(99) < rdy_prob);
         end
         #1;
         if (reset) begin
            hold_v = 1'b0;
            continue;
         end
         if (hold_v) begin
            check("hold_valid", m_valid, 1);
            check("hold_even", $signed(m_even), held_e);
            check("hold_odd", $signed(m_odd), held_o);
            check("hold_last", m_last, held_l);
         end
         hold_v = m_valid && !m_ready;
         held_e = $signed(m_even);
         held_o = $signed(m_odd);
         held_l = m_last;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               p = exp_q.pop_front();
               check("even", $signed(m_even), p.e);
               check("odd", $signed(m_odd), p.o);
               check("last", m_last, p.l);
            end
         end
         if (bp_check && m_valid && !m_ready) begin
            #1;
            check("bp_s_ready", s_ready, 0);
         end
      end
   end

   initial begin : stimulus
      int n;
      int gap;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_m_valid", m_valid, 0);
      check("rst_m_even", m_even, 0);
      check("rst_m_odd", m_odd, 0);
      check("rst_m_last", m_last, 0);
      check("rst_s_ready", s_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      #2;
      check("s_ready_pre_edge", s_ready, 0);
      @(posedge clk);
      #1;
      check("s_ready_post_edge", s_ready, 1);

      // Basic line followed back-to-back by a single-pair line: one bubble for FLUSH.
      rdy_prob = 100;
      acc_cyc.delete();
      cur_s = '{10, 20, 30};
      cur_d = '{2, 4, -2};
      push_exp(9, 15, 0);
      push_exp(18, 27, 0);
      push_exp(29, 27, 1);
      send_line(0);
      cur_s = '{5};
      cur_d = '{3};
      push_exp(3, 6, 1);
      send_line(0);
      check("accept_gap_0", acc_cyc[1] - acc_cyc[0], 1);
      check("accept_gap_1", acc_cyc[2] - acc_cyc[1], 1);
      check("accept_gap_flush", acc_cyc[3] - acc_cyc[2], 2);
      drain();
      #2;
      check("first_s_ready", s_ready, 1);

      cur_s = '{0, 0};
      cur_d = '{-3, -4};
      push_exp(1, -2, 0);
      push_exp(2, -2, 1);
      send_line(0);
      drain();

      cur_s = '{32767};
      cur_d = '{-32768};
      push_exp(32767, 16383, 1);
      send_line(0);
      drain();

      stall_arm = 1'b1;
      bp_check  = 1'b1;
      cur_s = '{10, 20, 30};
      cur_d = '{2, 4, -2};
      push_exp(9, 15, 0);
      push_exp(18, 27, 0);
      push_exp(29, 27, 1);
      send_line(0);
      drain();
      bp_check = 1'b0;

      // Abort a line mid-way; the pair already in the output register must vanish.
      rdy_prob = 0;
      repeat (2) @(negedge clk);
      send_pair(10, 2, 1'b0, 0);
      send_pair(20, 4, 1'b0, 0);
      @(negedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("abort_m_valid", m_valid, 0);
      check("abort_s_ready", s_ready, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rdy_prob = 100;
      cur_s = '{5};
      cur_d = '{3};
      push_exp(3, 6, 1);
      send_line(0);
      drain();

      for (int line = 0; line < 30; line++) begin
         rdy_prob = $urandom_range(40, 100);
         gap      = $urandom_range(0, 50);
         n        = $urandom_range(1, 8);
         cur_s.delete();
         cur_d.delete();
         for (int i = 0; i < n; i++) begin
            cur_s.push_back(rnd16());
            cur_d.push_back(rnd16());
         end
         model_line();
         send_line(gap);
      end
      rdy_prob = 100;
      drain();
      repeat (10) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/idwt53_stream.md
IDWT53_STREAM -- requirements
Module: idwt53_stream

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port s_valid, input, 1 bit: coefficient pair valid.
REQ-004 SHALL have port s_ready, output, 1 bit: block accepts pair this cycle.
REQ-005 SHALL have port s_low, input, 16 bits: signed approximation coefficient s[n].
REQ-006 SHALL have port s_high, input, 16 bits: signed detail coefficient d[n].
REQ-007 SHALL have port s_last, input, 1 bit: pair n is final pair of line (N = n+1).
REQ-008 SHALL have port m_valid, output, 1 bit: reconstructed sample pair valid.
REQ-009 SHALL have port m_ready, input, 1 bit: downstream accepts pair.
REQ-010 SHALL have port m_even, output, 16 bits: signed x[2k].
REQ-011 SHALL have port m_odd, output, 16 bits: signed x[2k+1].
REQ-012 SHALL have port m_last, output, 1 bit: marks final output pair of line.

Function
REQ-013 SHALL implement inverse integer LeGall 5/3 lifting: x[2n] = s[n] - floor((d[n-1] + d[n] + 2)/4); x[2n+1] = d[n] + floor((x[2n] + x[2n+2])/2).
REQ-014 SHALL apply symmetric boundary extension: d[-1] = d[0] at line start; x[2N] = x[2N-2] at line end.
REQ-015 SHALL compute floor division by arithmetic right shift (round toward minus infinity), never truncation toward zero.
REQ-016 SHALL carry internal even/odd values at 18 bits signed; recursion uses unsaturated internal values.
REQ-017 SHALL saturate m_even/m_odd to [-32768, 32767] only at the output register.
REQ-018 SHALL use an FSM with states FIRST (awaiting pair 0), RUN (pair n>0), FLUSH (emitting final pair).
REQ-019 FIRST: accepted pair computes x[0], stores x[0] and d[0], emits nothing; s_last=0 -> RUN; s_last=1 -> FLUSH.
REQ-020 RUN: accepted pair n computes x[2n], emits pair (x[2n-2], x[2n-1]) with m_last=0, stores x[2n], d[n]; s_last=1 -> FLUSH, else stay.
REQ-021 FLUSH: loads (x[2N-2], d[N-1] + x[2N-2]) with m_last=1 into the output register once it is free, then -> FIRST.
REQ-022 s_ready SHALL be 1 only in FIRST, or in RUN when output register is empty or being drained (m_valid=0 or m_ready=1); s_ready=0 in FLUSH.
REQ-023 Transfer occurs on s_valid&s_ready (input) and m_valid&m_ready (output); m_valid, m_even, m_odd, m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-024 Latency: output pair k registered on the clock edge accepting pair k+1 (or the FLUSH edge); m_valid rises one cycle after that acceptance.
REQ-025 With s_valid=1 and m_ready=1 continuously, throughput SHALL be one pair per cycle, plus one FLUSH cycle per line.
REQ-026 Single-pair line (s_last on pair 0) SHALL produce exactly one output pair with m_last=1.
REQ-027 s_low/s_high/s_last SHALL be ignored when s_ready=0.

Reset
REQ-028 While reset=1: state=FIRST, m_valid=0, m_even=0, m_odd=0, m_last=0, stored x/d=0, s_ready=0.
REQ-029 s_ready SHALL rise the first clock after reset deasserts; reset mid-line discards all partial line state and no stale pair is emitted.

Verification
REQ-030 (s,d) = (10,2),(20,4),(30,-2 last), m_ready=1 -> outputs (9,15),(18,27),(29,27 m_last=1), exactly 3 pairs.
REQ-031 Single pair (5,3 last) -> one output (3,6) m_last=1; then FIRST, s_ready=1.
REQ-032 Negative floor: (0,-3),(0,-4 last) -> (1,-2),(2,-2 last); truncation toward zero would wrongly give x[2]=1.
REQ-033 Saturation: (32767,-32768 last) -> (32767,16383 last); internal x[0]=49151 used unsaturated for odd.
REQ-034 Backpressure: REQ-030 stimulus with m_ready low for 3 cycles after first m_valid -> s_ready=0, outputs held stable, same 3 pairs in order, none lost or duplicated.
REQ-035 Reset after accepting (10,2),(20,4) -> m_valid=0 immediately; next line (5,3 last) -> (3,6 last), with no residue from the aborted line.
